// File: rtl/inst_fetch_seq_if.sv
// Memory read bus and instruction handshake between the fetch sequencer and its neighbours.
// The master side is the fetch sequencer; the slave side is memory plus the execute stage.
interface inst_fetch_seq_if #(
    parameter int INST_BYTES = 7,
    parameter int ADDR_W     = 16
);
    logic                    read;
    logic [ADDR_W-1:0]       address;
    logic [7:0]              din;
    logic                    mem_ready;
    logic                    inst_valid;
    logic [INST_BYTES*8-1:0] inst;
    logic [ADDR_W-1:0]       inst_pc;
    logic                    inst_ready;

    modport master (
        output read, address, inst_valid, inst, inst_pc,
        input  din, mem_ready, inst_ready
    );

    modport slave (
        input  read, address, inst_valid, inst, inst_pc,
        output din, mem_ready, inst_ready
    );
endinterface

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: reads INST_BYTES bytes from the PC over an 8-bit bus,
// assembles them MSB-first and hands the word to execute with valid/ready.
//
// state | meaning
// IDLE  | no fetch in progress, waiting for run
// FETCH | issuing byte reads at pc+byte_idx
// HOLD  | instruction word presented, waiting for inst_ready
module inst_fetch_seq #(
    parameter int INST_BYTES = 7,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_value,
    inst_fetch_seq_if.master  bus
);
    localparam int IDX_W  = $clog2(INST_BYTES);
    localparam int WORD_W = INST_BYTES * 8;
    localparam int ASM_W  = WORD_W - 8;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [IDX_W-1:0]  byte_idx;
    logic [ASM_W-1:0]  asm_q;
    logic [WORD_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              accept;
    logic              last_byte;
    logic              handoff;

    assign accept    = (state == FETCH) && bus.mem_ready;
    assign last_byte = accept && (byte_idx == IDX_W'(INST_BYTES - 1));
    assign handoff   = (state == HOLD) && bus.inst_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.read       = (state == FETCH);
        bus.inst_valid = (state == HOLD);
        bus.address    = pc + ADDR_W'(byte_idx);
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   if (last_byte) state_nxt = HOLD;
            HOLD:    if (bus.inst_ready) state_nxt = run ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
        // A PC reload overrides whatever the current state would do, including a handshake.
        if (pc_load) state_nxt = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else if (pc_load) begin
            pc       <= pc_value;
            byte_idx <= '0;
        end else begin
            if (state == IDLE) byte_idx <= '0;
            if (accept) begin
                asm_q    <= {asm_q[ASM_W-9:0], bus.din};
                byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
                if (last_byte) begin
                    inst_q    <= {asm_q, bus.din};
                    inst_pc_q <= pc;
                end
            end
            if (handoff) begin
                pc       <= pc + ADDR_W'(INST_BYTES);
                byte_idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed scenarios followed by a randomized run against a transaction-level fetch model.
module tb_inst_fetch_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        pc_load;
    logic [15:0] pc_value;
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    inst_fetch_seq_if #(.INST_BYTES(7), .ADDR_W(16)) bus ();

    assign bus.din = mem[bus.address];

    inst_fetch_seq #(.INST_BYTES(7), .ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .pc_load  (pc_load),
        .pc_value (pc_value),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] word_at(input logic [15:0] a);
        logic [55:0] w = '0;
        for (int k = 0; k < 7; k++) w = {w[47:0], mem[16'(a + k)]};
        return w;
    endfunction

    // Walks one full instruction with mem_ready=1, ending on the cycle the word is presented.
    task automatic walk(input logic [15:0] base, input string tag);
        for (int i = 0; i < 7; i++) begin
            chk({tag, "_read"}, bus.read, 1'b1);
            chk({tag, "_valid_low"}, bus.inst_valid, 1'b0);
            chk({tag, "_addr"}, bus.address, 16'(base + i));
            cyc();
        end
        chk({tag, "_valid"}, bus.inst_valid, 1'b1);
        chk({tag, "_read_low"}, bus.read, 1'b0);
        chk({tag, "_inst_pc"}, bus.inst_pc, base);
        chk({tag, "_inst"}, bus.inst, word_at(base));
    endtask

    initial begin
        logic [15:0] mpc;
        int          cnt;
        bit          have;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 7; i++) mem[i] = 8'(i + 1);

        rst = 1'b0; run = 1'b0; pc_load = 1'b0; pc_value = '0;
        bus.mem_ready = 1'b0; bus.inst_ready = 1'b0;
        cyc(); cyc();
        chk("rst_read", bus.read, 1'b0);
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", bus.inst, 56'h0);
        chk("rst_inst_pc", bus.inst_pc, 16'h0);
        chk("rst_addr", bus.address, 16'h0);

        // 1: back-to-back fetch of 01..07
        rst = 1'b1; run = 1'b1; bus.mem_ready = 1'b1; bus.inst_ready = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            chk("t1_read", bus.read, 1'b1);
            chk("t1_addr", bus.address, 16'(i));
            cyc();
        end
        chk("t1_valid", bus.inst_valid, 1'b1);
        chk("t1_read_low", bus.read, 1'b0);
        chk("t1_inst", bus.inst, 56'h01020304050607);
        chk("t1_inst_pc", bus.inst_pc, 16'h0);
        cyc();
        chk("t1_next_addr", bus.address, 16'h0007);
        chk("t1_next_read", bus.read, 1'b1);

        // 2: restart at 0 (read accepted this cycle is discarded), stall 3 cycles on byte 2
        pc_load = 1'b1; pc_value = 16'h0000;
        cyc();
        pc_load = 1'b0;
        chk("t2_addr0", bus.address, 16'h0000); cyc();
        chk("t2_addr1", bus.address, 16'h0001); cyc();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_read", bus.read, 1'b1);
            chk("t2_stall_addr", bus.address, 16'h0002);
            cyc();
        end
        bus.mem_ready = 1'b1;
        for (int i = 2; i < 7; i++) begin
            chk("t2_addr", bus.address, 16'(i));
            if (i == 6) bus.inst_ready = 1'b0;
            cyc();
        end

        // 3: execute stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", bus.inst_valid, 1'b1);
            chk("t3_read_low", bus.read, 1'b0);
            chk("t3_inst", bus.inst, 56'h01020304050607);
            chk("t3_inst_pc", bus.inst_pc, 16'h0);
            cyc();
        end
        bus.inst_ready = 1'b1;
        cyc();
        chk("t3_valid_drop", bus.inst_valid, 1'b0);
        chk("t3_next_addr", bus.address, 16'h0007);

        // 4: pc_load mid-fetch after four bytes
        for (int i = 1; i < 5; i++) begin
            cyc();
            chk("t4_pre_addr", bus.address, 16'(7 + i));
            chk("t4_pre_valid", bus.inst_valid, 1'b0);
        end
        pc_load = 1'b1; pc_value = 16'h1234;
        cyc();
        pc_load = 1'b0;
        walk(16'h1234, "t4");
        cyc();
        chk("t4_next_addr", bus.address, 16'h123B);

        // 5: address wrap
        pc_load = 1'b1; pc_value = 16'hFFFD;
        cyc();
        pc_load = 1'b0;
        walk(16'hFFFD, "t5");
        cyc();
        chk("t5_next_addr", bus.address, 16'h0004);

        // 6: run dropped mid-fetch
        run = 1'b0;
        walk(16'h0004, "t6");
        cyc();
        chk("t6_idle_read", bus.read, 1'b0);
        chk("t6_idle_valid", bus.inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_idle_hold", bus.read, 1'b0);
        end
        run = 1'b1;
        cyc();
        chk("t6_resume_read", bus.read, 1'b1);
        chk("t6_resume_addr", bus.address, 16'h000B);

        // 7: pc_load in HOLD with inst_ready=1 drops the word and does not advance the PC
        walk(16'h000B, "t7a");
        pc_load = 1'b1; pc_value = 16'h0100;
        cyc();
        pc_load = 1'b0;
        chk("t7_valid_drop", bus.inst_valid, 1'b0);
        walk(16'h0100, "t7b");
        cyc();
        chk("t7_next_addr", bus.address, 16'h0107);

        // 8: asynchronous reset mid-fetch
        cyc(); cyc();
        #2 rst = 1'b0;
        #1;
        chk("t8_read", bus.read, 1'b0);
        chk("t8_valid", bus.inst_valid, 1'b0);
        chk("t8_inst", bus.inst, 56'h0);
        chk("t8_inst_pc", bus.inst_pc, 16'h0);
        cyc();
        rst = 1'b1; run = 1'b0;
        cyc();
        chk("t8_idle", bus.read, 1'b0);

        // 9: random memory/execute backpressure against the transaction model
        run = 1'b1; pc_load = 1'b1; pc_value = 16'($urandom);
        mpc = pc_value; cnt = 0; have = 1'b0;
        cyc();
        pc_load = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.mem_ready  = ($urandom_range(0, 3) != 0);
            bus.inst_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_read", bus.read, !have);
            chk("rnd_valid", bus.inst_valid, have);
            if (!have) chk("rnd_addr", bus.address, 16'(mpc + cnt));
            if (have) begin
                chk("rnd_inst", bus.inst, word_at(mpc));
                chk("rnd_inst_pc", bus.inst_pc, mpc);
            end
            if (!have && bus.mem_ready) begin
                cnt++;
                if (cnt == 7) begin
                    cnt = 0;
                    have = 1'b1;
                end
            end else if (have && bus.inst_ready) begin
                have = 1'b0;
                mpc = 16'(mpc + 7);
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
